mantissa_seq: RTL and testbench
===============================

# mantissa_seq

Sequencer for the FPU mantissa datapath register file (a1/a0/b1/b0). It accepts one operation at a time: operand load, then either a fixed-count right-shift alignment loop or a left-shift normalize loop, then one or two output-packing cycles. It drives every select line of the datapath and stalls with it under `fpuhold`. It sits between FPU microcode control and the mantissa datapath.

## Interface
- CNT_W, 6, width of shift count and normalize count

Ports:
- clk  in  1  clock
- reset_l  in  1  synchronous active-low reset
- fpuhold  in  1  global stall; datapath registers and this block freeze
- start  in  1  request; accepted only in IDLE with fpuhold=0
- op  in  1  0=ALIGN (right shift shcnt times), 1=NORM (left shift until amsb)
- dbl  in  1  1=double format, 0=single; sampled with start
- shcnt  in  CNT_W  ALIGN shift count; sampled with start
- amsb, a1comp, a0comp  in  1 each  datapath status (a1[31], a1[30:0]==0, a0==0)
- busy  out  1  state != IDLE
- done  out  1  final output cycle, qualified by ~fpuhold
- zero_res  out  1  NORM found all-zero mantissa; valid with done
- norm_cnt  out  CNT_W  left shifts performed; valid with done
- cyc0_rdy  out  1  operand-load cycle
- a1sel[2:0], a1psel[1:0], a1zzsel, a0sel[2:0], a0psel[2:0], cyc0_sel[1:0], b0sel_a[1:0], b0sel_b[1:0], b1sel[1:0], b1psel, b1_cyc0sel, fp_out_sel[2:0]  out  datapath selects

## Operation
- States: IDLE, LOAD, ITER, OUT_HI, OUT_LO. Latches: op_r, dbl_r, cnt[CNT_W-1:0], norm_cnt, zero_res.
- Hold encoding applies in IDLE, OUT_HI, OUT_LO, and NORM cycles with amsb=1:
  - a1sel=6, a1zzsel=0 (a1 holds)
  - a0sel=3, a0psel=0 (a0 holds)
  - b0sel_a=b0sel_b=0, b1sel=0, b1_cyc0sel=0
  - cyc0_sel=0, a1psel=0, b1psel=0, fp_out_sel=0
- IDLE: on start, latch op/dbl/shcnt, clear norm_cnt and zero_res, go to LOAD.
- LOAD: cyc0_rdy=1 and b1_cyc0sel=1.
  - dbl: a1psel=3, b1psel=1, cyc0_sel=1.
  - single: a1psel=1, b1psel=0, cyc0_sel=0.
  - Next state: ALIGN with cnt=0 goes to OUT_HI; otherwise ITER.
- ITER, ALIGN: a1sel=1, a0sel=0 (rsout). cnt decrements each cycle; leave to OUT_HI after the cycle in which cnt==1. Exactly shcnt shifts occur.
- ITER, NORM: the first matching rule applies.
  1. amsb=1: hold, go to OUT_HI.
  2. a1comp & a0comp: hold, set zero_res, go to OUT_HI.
  3. Otherwise: a1sel=2, a0sel=2 (lsout), norm_cnt+1. If norm_cnt reaches 2^CNT_W-1, go to OUT_HI next.
- OUT_HI:
  - single: fp_out_sel=5, done, go to IDLE.
  - dbl: fp_out_sel=3, go to OUT_LO.
- OUT_LO: fp_out_sel=4, done, go to IDLE.
- start outside IDLE is ignored; there is no queue.

## Timing
- All outputs are Moore decodes of registered state, except the NORM ITER selects, which depend on amsb/a1comp/a0comp of the current cycle, and done, which is gated by ~fpuhold.
- Reset (reset_l=0 at a clk edge): state=IDLE, cnt=0, norm_cnt=0, zero_res=0. All outputs read 0, except the hold encoding (a1sel=6, a0sel=3). Reset mid-operation aborts immediately with no done.
- fpuhold=1: state, cnt, norm_cnt and zero_res do not change. Selects stay stable, done=0, start is not accepted.
- Latency from the start cycle to done, with no holds:
  - ALIGN single: 2+shcnt+1 cycles; dbl: 2+shcnt+2.
  - NORM: 2 + (shifts+1) + (1 single / 2 dbl) cycles.
- busy rises the cycle after start is accepted and falls the cycle after done.
- norm_cnt and zero_res stay stable from done until the next accepted start.

## Test plan
- Reset then idle: busy=0, done=0, a1sel=6, a0sel=3, fp_out_sel=0. start with op=0, dbl=0, shcnt=3 → LOAD (cyc0_rdy=1, a1psel=1), 3 ITER cycles with a1sel=1, OUT_HI with fp_out_sel=5 and done=1 on cycle 6.
- ALIGN dbl shcnt=0 → LOAD (a1psel=3, cyc0_sel=1, b1psel=1), then OUT_HI fp_out_sel=3, then OUT_LO fp_out_sel=4 with done; no rsout select ever issued.
- NORM with amsb low for 5 ITER cycles, then high → exactly 5 lsout cycles, norm_cnt=5, zero_res=0, done on the following output cycle.
- NORM with a1comp=a0comp=1 and amsb=0 → first ITER holds, zero_res=1, norm_cnt=0; NORM with amsb never high and comps low → saturates at norm_cnt=63.
- fpuhold pulsed for 4 cycles mid-ITER (ALIGN shcnt=10) and during OUT_LO → exactly 10 shift cycles with hold low, done deasserted while held, asserted once on release; a start issued while busy is ignored.
- reset_l driven low during ITER → next cycle IDLE, busy=0, norm_cnt=0, no done.

Source files
------------

// File: rtl/mantissa_seq_if.sv
// mantissa_seq_if
//   Bundles the microcode request, the datapath status inputs, and every
//   result/select line of the mantissa sequencer.
//   master : microcode/datapath side (drives start/op/dbl/shcnt and status)
//   slave  : the sequencer (drives busy/done/results and all selects)
interface mantissa_seq_if #(
    parameter int unsigned CNT_W = 6
);
    // Request
    logic             start;
    logic             op;
    logic             dbl;
    logic [CNT_W-1:0] shcnt;

    // Datapath status
    logic             amsb;
    logic             a1comp;
    logic             a0comp;

    // Status / results
    logic             busy;
    logic             done;
    logic             zero_res;
    logic [CNT_W-1:0] norm_cnt;
    logic             cyc0_rdy;

    // Datapath selects
    logic [2:0]       a1sel;
    logic [1:0]       a1psel;
    logic             a1zzsel;
    logic [2:0]       a0sel;
    logic [2:0]       a0psel;
    logic [1:0]       cyc0_sel;
    logic [1:0]       b0sel_a;
    logic [1:0]       b0sel_b;
    logic [1:0]       b1sel;
    logic             b1psel;
    logic             b1_cyc0sel;
    logic [2:0]       fp_out_sel;

    modport master (
        output start, op, dbl, shcnt, amsb, a1comp, a0comp,
        input  busy, done, zero_res, norm_cnt, cyc0_rdy,
               a1sel, a1psel, a1zzsel, a0sel, a0psel, cyc0_sel,
               b0sel_a, b0sel_b, b1sel, b1psel, b1_cyc0sel, fp_out_sel
    );

    modport slave (
        input  start, op, dbl, shcnt, amsb, a1comp, a0comp,
        output busy, done, zero_res, norm_cnt, cyc0_rdy,
               a1sel, a1psel, a1zzsel, a0sel, a0psel, cyc0_sel,
               b0sel_a, b0sel_b, b1sel, b1psel, b1_cyc0sel, fp_out_sel
    );
endinterface

// File: rtl/mantissa_seq.sv
// mantissa_seq
//   Sequencer for the FPU mantissa register file (a1/a0/b1/b0). Runs one
//   operation at a time: operand load, then a fixed-count right-shift align
//   loop or a left-shift normalize loop, then one (single) or two (double)
//   output-packing cycles. Everything freezes while fpuhold is high.
// Ports
//   clk      : clock
//   reset_l  : synchronous active-low reset
//   fpuhold  : global stall
//   bus      : mantissa_seq_if.slave (request, datapath status, results,
//              datapath select lines)
module mantissa_seq #(
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 fpuhold,
    mantissa_seq_if.slave        bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_OUT_HI,
        S_OUT_LO
    } state_t;

    state_t           state, state_nxt;
    logic             op_r, op_nxt;
    logic             dbl_r, dbl_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] norm_cnt_r, norm_cnt_nxt;
    logic             zero_r, zero_nxt;

    // State register and operation latches
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state      <= S_IDLE;
            op_r       <= 1'b0;
            dbl_r      <= 1'b0;
            cnt        <= '0;
            norm_cnt_r <= '0;
            zero_r     <= 1'b0;
        end else if (!fpuhold) begin
            state      <= state_nxt;
            op_r       <= op_nxt;
            dbl_r      <= dbl_nxt;
            cnt        <= cnt_nxt;
            norm_cnt_r <= norm_cnt_nxt;
            zero_r     <= zero_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        op_nxt       = op_r;
        dbl_nxt      = dbl_r;
        cnt_nxt      = cnt;
        norm_cnt_nxt = norm_cnt_r;
        zero_nxt     = zero_r;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt    = S_LOAD;
                    op_nxt       = bus.op;
                    dbl_nxt      = bus.dbl;
                    cnt_nxt      = bus.shcnt;
                    norm_cnt_nxt = '0;
                    zero_nxt     = 1'b0;
                end
            end
            S_LOAD: begin
                // A zero-length align skips the loop entirely
                if (!op_r && (cnt == '0)) state_nxt = S_OUT_HI;
                else                      state_nxt = S_ITER;
            end
            S_ITER: begin
                if (!op_r) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_nxt = S_OUT_HI;
                end else if (bus.amsb) begin
                    state_nxt = S_OUT_HI;
                end else if (bus.a1comp && bus.a0comp) begin
                    zero_nxt  = 1'b1;
                    state_nxt = S_OUT_HI;
                end else begin
                    norm_cnt_nxt = norm_cnt_r + CNT_W'(1);
                    // Saturate: the shift that fills the counter is the last
                    if (norm_cnt_nxt == CNT_MAX) state_nxt = S_OUT_HI;
                end
            end
            S_OUT_HI: state_nxt = dbl_r ? S_OUT_LO : S_IDLE;
            S_OUT_LO: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode; defaults are the hold encoding
    always_comb begin
        bus.busy       = (state != S_IDLE);
        bus.done       = 1'b0;
        bus.cyc0_rdy   = 1'b0;
        bus.a1sel      = 3'd6;
        bus.a1zzsel    = 1'b0;
        bus.a0sel      = 3'd3;
        bus.a0psel     = 3'd0;
        bus.b0sel_a    = 2'd0;
        bus.b0sel_b    = 2'd0;
        bus.b1sel      = 2'd0;
        bus.b1_cyc0sel = 1'b0;
        bus.cyc0_sel   = 2'd0;
        bus.a1psel     = 2'd0;
        bus.b1psel     = 1'b0;
        bus.fp_out_sel = 3'd0;
        case (state)
            S_LOAD: begin
                bus.cyc0_rdy   = 1'b1;
                bus.b1_cyc0sel = 1'b1;
                if (dbl_r) begin
                    bus.a1psel   = 2'd3;
                    bus.b1psel   = 1'b1;
                    bus.cyc0_sel = 2'd1;
                end else begin
                    bus.a1psel   = 2'd1;
                end
            end
            S_ITER: begin
                if (!op_r) begin
                    bus.a1sel = 3'd1;
                    bus.a0sel = 3'd0;
                end else if (!bus.amsb && !(bus.a1comp && bus.a0comp)) begin
                    bus.a1sel = 3'd2;
                    bus.a0sel = 3'd2;
                end
            end
            S_OUT_HI: begin
                bus.fp_out_sel = dbl_r ? 3'd3 : 3'd5;
                bus.done       = !dbl_r && !fpuhold;
            end
            S_OUT_LO: begin
                bus.fp_out_sel = 3'd4;
                bus.done       = !fpuhold;
            end
            default: ;
        endcase
    end

    assign bus.norm_cnt = norm_cnt_r;
    assign bus.zero_res = zero_r;

endmodule

// File: tb/tb_mantissa_seq.sv
// tb_mantissa_seq
//   Directed-vector bench for mantissa_seq with hand-computed expectations.
module tb_mantissa_seq;

    logic clk;
    logic reset_l;
    logic fpuhold;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mantissa_seq_if #(.CNT_W(6)) bus ();

    mantissa_seq #(.CNT_W(6)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .fpuhold (fpuhold),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic op_i, input logic dbl_i, input logic [5:0] sh_i);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.dbl   = dbl_i;
        bus.shcnt = sh_i;
        step();
        bus.start = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned shifts;
        int unsigned dones;
        int unsigned lo_hold;

        reset_l    = 1'b0;
        fpuhold    = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 1'b0;
        bus.dbl    = 1'b0;
        bus.shcnt  = '0;
        bus.amsb   = 1'b0;
        bus.a1comp = 1'b0;
        bus.a0comp = 1'b0;
        step();
        step();
        reset_l = 1'b1;
        #1;

        // Reset / idle
        check("rst_busy",   bus.busy, 0);
        check("rst_done",   bus.done, 0);
        check("rst_a1sel",  bus.a1sel, 6);
        check("rst_a0sel",  bus.a0sel, 3);
        check("rst_fpout",  bus.fp_out_sel, 0);
        check("rst_cyc0",   bus.cyc0_rdy, 0);
        check("rst_ncnt",   bus.norm_cnt, 0);
        check("rst_zero",   bus.zero_res, 0);

        // ALIGN single, shcnt=3
        req(1'b0, 1'b0, 6'd3);
        check("al1_cyc0",   bus.cyc0_rdy, 1);
        check("al1_a1psel", bus.a1psel, 1);
        check("al1_b1c0",   bus.b1_cyc0sel, 1);
        check("al1_c0sel",  bus.cyc0_sel, 0);
        check("al1_busy",   bus.busy, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("al1_a1sel",  bus.a1sel, 1);
            check("al1_a0sel",  bus.a0sel, 0);
            check("al1_done_n", bus.done, 0);
        end
        step();
        check("al1_fpout",  bus.fp_out_sel, 5);
        check("al1_done",   bus.done, 1);
        step();
        check("al1_idle",   bus.busy, 0);
        check("al1_done_0", bus.done, 0);

        // ALIGN dbl, shcnt=0
        req(1'b0, 1'b1, 6'd0);
        check("al0_a1psel", bus.a1psel, 3);
        check("al0_c0sel",  bus.cyc0_sel, 1);
        check("al0_b1psel", bus.b1psel, 1);
        check("al0_a1sel",  bus.a1sel, 6);
        step();
        check("al0_hi_fp",  bus.fp_out_sel, 3);
        check("al0_hi_dn",  bus.done, 0);
        check("al0_hi_a1",  bus.a1sel, 6);
        step();
        check("al0_lo_fp",  bus.fp_out_sel, 4);
        check("al0_lo_dn",  bus.done, 1);
        check("al0_lo_a1",  bus.a1sel, 6);
        step();
        check("al0_idle",   bus.busy, 0);

        // NORM single, 5 shifts then amsb
        req(1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("nm5_a1sel", bus.a1sel, 2);
            check("nm5_a0sel", bus.a0sel, 2);
        end
        step();
        bus.amsb = 1'b1;
        #1;
        check("nm5_hold",   bus.a1sel, 6);
        check("nm5_ncnt_i", bus.norm_cnt, 5);
        step();
        bus.amsb = 1'b0;
        #1;
        check("nm5_done",   bus.done, 1);
        check("nm5_fpout",  bus.fp_out_sel, 5);
        check("nm5_ncnt",   bus.norm_cnt, 5);
        check("nm5_zero",   bus.zero_res, 0);
        step();
        check("nm5_idle",   bus.busy, 0);
        check("nm5_keep",   bus.norm_cnt, 5);

        // NORM dbl, all-zero mantissa
        bus.a1comp = 1'b1;
        bus.a0comp = 1'b1;
        req(1'b1, 1'b1, 6'd0);
        check("nz_ncnt_clr", bus.norm_cnt, 0);
        step();
        check("nz_hold",    bus.a1sel, 6);
        step();
        check("nz_zero",    bus.zero_res, 1);
        check("nz_ncnt",    bus.norm_cnt, 0);
        check("nz_hi_fp",   bus.fp_out_sel, 3);
        check("nz_hi_dn",   bus.done, 0);
        step();
        check("nz_lo_dn",   bus.done, 1);
        check("nz_lo_fp",   bus.fp_out_sel, 4);
        step();
        bus.a1comp = 1'b0;
        bus.a0comp = 1'b0;
        #1;

        // NORM saturation
        req(1'b1, 1'b0, 6'd0);
        check("sat_zero_clr", bus.zero_res, 0);
        step();
        n = 0;
        while (bus.a1sel == 3'd2 && n < 100) begin
            n++;
            step();
        end
        check("sat_shifts", n, 63);
        check("sat_ncnt",   bus.norm_cnt, 63);
        check("sat_done",   bus.done, 1);
        check("sat_fpout",  bus.fp_out_sel, 5);
        step();

        // ALIGN dbl shcnt=10 with holds mid-ITER and in OUT_LO, stray start
        req(1'b0, 1'b1, 6'd10);
        check("hd_ncnt_clr", bus.norm_cnt, 0);
        shifts  = 0;
        dones   = 0;
        lo_hold = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            fpuhold   = (k >= 3 && k <= 6);
            bus.start = (k == 1);
            bus.op    = (k == 1);
            if (bus.fp_out_sel == 3'd4 && lo_hold < 4) begin
                fpuhold = 1'b1;
                lo_hold++;
            end
            #1;
            if (bus.a1sel == 3'd1 && !fpuhold) shifts++;
            if (bus.done) dones++;
            if (fpuhold) check("hd_done_held", bus.done, 0);
        end
        fpuhold   = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        #1;
        check("hd_shifts",  shifts, 10);
        check("hd_dones",   dones, 1);
        check("hd_lohold",  lo_hold, 4);
        check("hd_idle",    bus.busy, 0);

        // Reset during NORM ITER
        req(1'b1, 1'b0, 6'd0);
        step();
        step();
        check("rs_ncnt_pre", bus.norm_cnt, 1);
        check("rs_busy_pre", bus.busy, 1);
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
        #1;
        check("rs_busy",    bus.busy, 0);
        check("rs_ncnt",    bus.norm_cnt, 0);
        check("rs_done",    bus.done, 0);
        check("rs_a1sel",   bus.a1sel, 6);
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.done || bus.busy) dones++;
        end
        check("rs_quiet",   dones, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
